// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline stall/flush controller with store-commit sequencing,
//            exception redirect and a saturating stall-cycle counter.
// Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int STAGES     = 6,
    parameter int MEM_STAGE  = 4,
    parameter int STORE_WAIT = 1,
    parameter bit VECTORED   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-2:0] stallreq_i,
    input  logic              mem_we_i,
    input  logic [31:0]       excepttype_i,
    input  logic [31:0]       ebase_i,
    input  logic [31:0]       cp0_epc_i,
    input  logic              cnt_clr_i,
    output logic [STAGES-1:0] stall,
    output logic              flush,
    output logic [31:0]       new_pc,
    output logic              mem_we_o,
    output logic [31:0]       stall_cnt_o
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [3:0]        C_WAIT_LOAD  = 4'(STORE_WAIT - 1);
    localparam logic [STAGES-1:0] C_ONES       = '1;
    localparam logic [STAGES-1:0] C_MASK_MEM   = C_ONES >> (STAGES - 1 - MEM_STAGE);
    localparam logic [STAGES-1:0] C_MASK_MEM1  = C_ONES >> (STAGES - MEM_STAGE);
    localparam logic [31:0]       C_EXC_INT    = 32'h0000_0001;
    localparam logic [31:0]       C_EXC_ERET   = 32'h0000_000E;
    localparam logic [31:0]       C_EXC_TLB    = 32'h0000_000F;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nx;
    logic [3:0]        r_wcnt;
    logic [3:0]        w_wcnt_nx;
    logic [31:0]       r_stall_cnt;
    logic [STAGES-1:0] w_req_mask;
    logic [STAGES-1:0] w_store_mask;
    logic              w_store_we;
    logic              w_exc;
    logic [31:0]       w_exc_pc;

    assign w_exc       = (excepttype_i != 32'd0);
    assign stall_cnt_o = r_stall_cnt;

    // A request from stage k stalls every stage at or below k.
    always_comb begin
        w_req_mask = '0;
        for (int k = 0; k < STAGES - 1; k++) begin
            if (stallreq_i[k]) begin
                w_req_mask = w_req_mask | (C_ONES >> (STAGES - 1 - k));
            end
        end
    end

    always_comb begin
        w_exc_pc = ebase_i;
        if (excepttype_i == C_EXC_ERET) begin
            w_exc_pc = cp0_epc_i;
        end else if (VECTORED) begin
            if (excepttype_i == C_EXC_INT) begin
                w_exc_pc = ebase_i + 32'h0000_0200;
            end else if (excepttype_i == C_EXC_TLB) begin
                w_exc_pc = ebase_i;
            end else begin
                w_exc_pc = ebase_i + 32'h0000_0180;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wcnt      <= 4'd0;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_state_nx;
            r_wcnt  <= w_wcnt_nx;
            if (cnt_clr_i) begin
                r_stall_cnt <= 32'd0;
            end else if ((stall != '0) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = r_wcnt;
        if (w_exc) begin
            w_state_nx = S_IDLE;
            w_wcnt_nx  = 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mem_we_i) begin
                        // The IDLE cycle already counts as the first stall cycle.
                        w_wcnt_nx  = C_WAIT_LOAD;
                        w_state_nx = (C_WAIT_LOAD == 4'd0) ? S_COMMIT : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!mem_we_i) begin
                        w_state_nx = S_IDLE;
                        w_wcnt_nx  = 4'd0;
                    end else if (r_wcnt <= 4'd1) begin
                        w_state_nx = S_COMMIT;
                        w_wcnt_nx  = 4'd0;
                    end else begin
                        w_wcnt_nx = r_wcnt - 4'd1;
                    end
                end
                S_COMMIT: begin
                    w_state_nx = S_HOLD;
                end
                default: begin
                    // Leave once the committed store has moved out of the memory stage.
                    if (!mem_we_i || !w_req_mask[MEM_STAGE]) begin
                        w_state_nx = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_store_mask = '0;
        w_store_we   = 1'b0;
        case (r_state)
            S_IDLE, S_WAIT: begin
                if (mem_we_i) begin
                    w_store_mask = C_MASK_MEM;
                end
            end
            S_COMMIT: begin
                w_store_mask = C_MASK_MEM1;
                w_store_we   = 1'b1;
            end
            default: ;
        endcase

        stall    = '0;
        flush    = 1'b0;
        new_pc   = 32'd0;
        mem_we_o = 1'b0;
        if (rst) begin
            if (w_exc) begin
                flush  = 1'b1;
                new_pc = w_exc_pc;
            end else begin
                stall    = w_req_mask | w_store_mask;
                mem_we_o = w_store_we;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl (two parameterisations).
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int C_MEM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  stallreq_i;
    logic        mem_we_i;
    logic [31:0] excepttype_i;
    logic [31:0] ebase_i;
    logic [31:0] cp0_epc_i;
    logic        cnt_clr_i;

    logic [5:0]  stall0, stall1;
    logic        flush0, flush1;
    logic [31:0] pc0, pc1;
    logic        we0, we1;
    logic [31:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    int     m_age  [2];
    bit     m_hold [2];
    longint m_cnt  [2];

    typedef struct {
        logic        rst;
        logic [4:0]  req;
        logic        we;
        logic [31:0] exc;
        logic [31:0] ebase;
        logic [31:0] epc;
        logic [5:0]  x_stall;
        logic        x_flush;
        logic [31:0] x_pc;
        logic        x_we;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    pipe_ctrl #(.STAGES(6), .MEM_STAGE(4), .STORE_WAIT(1), .VECTORED(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .mem_we_i(mem_we_i),
        .excepttype_i(excepttype_i), .ebase_i(ebase_i), .cp0_epc_i(cp0_epc_i),
        .cnt_clr_i(cnt_clr_i), .stall(stall0), .flush(flush0), .new_pc(pc0),
        .mem_we_o(we0), .stall_cnt_o(cnt0)
    );

    pipe_ctrl #(.STAGES(6), .MEM_STAGE(4), .STORE_WAIT(3), .VECTORED(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .mem_we_i(mem_we_i),
        .excepttype_i(excepttype_i), .ebase_i(ebase_i), .cp0_epc_i(cp0_epc_i),
        .cnt_clr_i(cnt_clr_i), .stall(stall1), .flush(flush1), .new_pc(pc1),
        .mem_we_o(we1), .stall_cnt_o(cnt1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sw_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [5:0] mask(input int k);
        return 6'((1 << (k + 1)) - 1);
    endfunction

    // Stage j stalls when any stage at or above j requests.
    function automatic logic [5:0] req_mask(input logic [4:0] r);
        logic [5:0] m;
        m = '0;
        for (int j = 0; j < 6; j++) begin
            if ((r >> j) != 5'd0) m[j] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] exc_pc(input int i);
        if (excepttype_i == 32'h0E) return cp0_epc_i;
        if (i == 0) return ebase_i;
        case (excepttype_i)
            32'h01:  return ebase_i + 32'h200;
            32'h0F:  return ebase_i;
            default: return ebase_i + 32'h180;
        endcase
    endfunction

    // m_age: stall cycles already spent on the current store; at STORE_WAIT it commits.
    task automatic model_out(input int i, output logic [5:0] st, output logic fl,
                             output logic [31:0] pc, output logic we);
        st = '0; fl = 1'b0; pc = '0; we = 1'b0;
        if (rst === 1'b1) begin
            if (excepttype_i != 32'd0) begin
                fl = 1'b1;
                pc = exc_pc(i);
            end else begin
                st = req_mask(stallreq_i);
                if (m_hold[i]) begin
                end else if (m_age[i] == sw_of(i)) begin
                    st = st | mask(C_MEM - 1);
                    we = 1'b1;
                end else if (mem_we_i) begin
                    st = st | mask(C_MEM);
                end
            end
        end
    endtask

    task automatic model_reset_all();
        for (int i = 0; i < 2; i++) begin
            m_age[i] = 0; m_hold[i] = 1'b0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        logic [5:0] st; logic fl, we; logic [31:0] pc;
        if (rst !== 1'b1) begin
            m_age[i] = 0; m_hold[i] = 1'b0; m_cnt[i] = 0;
        end else begin
            model_out(i, st, fl, pc, we);
            if (cnt_clr_i) m_cnt[i] = 0;
            else if (st != 6'd0 && m_cnt[i] < 64'hFFFF_FFFF) m_cnt[i]++;
            if (excepttype_i != 32'd0) begin
                m_age[i] = 0; m_hold[i] = 1'b0;
            end else if (m_hold[i]) begin
                if (!mem_we_i || req_mask(stallreq_i)[C_MEM] == 1'b0) m_hold[i] = 1'b0;
            end else if (m_age[i] == sw_of(i)) begin
                m_age[i] = 0; m_hold[i] = 1'b1;
            end else if (mem_we_i) begin
                m_age[i]++;
            end else begin
                m_age[i] = 0;
            end
        end
    endtask

    task automatic settle();
        logic [5:0] st; logic fl, we; logic [31:0] pc;
        #2;
        for (int i = 0; i < 2; i++) begin
            model_out(i, st, fl, pc, we);
            chk($sformatf("dut%0d stall", i), 32'(i == 0 ? stall0 : stall1), 32'(st));
            chk($sformatf("dut%0d flush", i), 32'(i == 0 ? flush0 : flush1), 32'(fl));
            chk($sformatf("dut%0d new_pc", i), (i == 0 ? pc0 : pc1), pc);
            chk($sformatf("dut%0d mem_we_o", i), 32'(i == 0 ? we0 : we1), 32'(we));
            chk($sformatf("dut%0d stall_cnt", i), (i == 0 ? cnt0 : cnt1), 32'(m_cnt[i]));
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic drive_idle();
        rst = 1'b1; stallreq_i = '0; mem_we_i = 1'b0; excepttype_i = '0;
        ebase_i = '0; cp0_epc_i = '0; cnt_clr_i = 1'b0;
    endtask

    initial begin
        rst = 1'b0; stallreq_i = '0; mem_we_i = 1'b0; excepttype_i = '0;
        ebase_i = '0; cp0_epc_i = '0; cnt_clr_i = 1'b0;
        model_reset_all();

        // Expected values below are for the default parameterisation (dut0).
        tbl[0]  = '{1'b0, 5'b11111, 1'b1, 32'h0E, 32'h0, 32'h1234, 6'b000000, 1'b0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 5'b00000, 1'b0, 32'h0,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 5'b00000, 1'b1, 32'h0,  32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 5'b00000, 1'b1, 32'h0,  32'h0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1};
        tbl[4]  = '{1'b1, 5'b00000, 1'b0, 32'h0,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0};
        tbl[5]  = '{1'b1, 5'b00100, 1'b1, 32'h0,  32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0};
        tbl[6]  = '{1'b1, 5'b01000, 1'b1, 32'h0,  32'h0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b1};
        tbl[7]  = '{1'b1, 5'b10000, 1'b1, 32'h0,  32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0};
        tbl[8]  = '{1'b1, 5'b00000, 1'b1, 32'h0,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0};
        tbl[9]  = '{1'b1, 5'b00000, 1'b1, 32'h0,  32'h0, 32'h0, 6'b011111, 1'b0, 32'h0, 1'b0};
        tbl[10] = '{1'b1, 5'b00000, 1'b1, 32'h0E, 32'h0, 32'h80001234, 6'b000000, 1'b1, 32'h80001234, 1'b0};
        tbl[11] = '{1'b1, 5'b01000, 1'b0, 32'h0,  32'h0, 32'h0, 6'b001111, 1'b0, 32'h0, 1'b0};
        tbl[12] = '{1'b1, 5'b00000, 1'b0, 32'h05, 32'h80000000, 32'h0, 6'b000000, 1'b1, 32'h80000000, 1'b0};
        tbl[13] = '{1'b1, 5'b00000, 1'b0, 32'h0,  32'h0, 32'h0, 6'b000000, 1'b0, 32'h0, 1'b0};

        for (int r = 0; r < 14; r++) begin
            rst = tbl[r].rst; stallreq_i = tbl[r].req; mem_we_i = tbl[r].we;
            excepttype_i = tbl[r].exc; ebase_i = tbl[r].ebase; cp0_epc_i = tbl[r].epc;
            cnt_clr_i = 1'b0;
            if (!rst) model_reset_all();
            settle();
            chk($sformatf("row%0d stall", r), 32'(stall0), 32'(tbl[r].x_stall));
            chk($sformatf("row%0d flush", r), 32'(flush0), 32'(tbl[r].x_flush));
            chk($sformatf("row%0d new_pc", r), pc0, tbl[r].x_pc);
            chk($sformatf("row%0d mem_we_o", r), 32'(we0), 32'(tbl[r].x_we));
            advance();
        end

        // STORE_WAIT=3: three memory-stage stall cycles, then one strobe.
        drive_idle(); cnt_clr_i = 1'b1;
        settle(); advance();
        cnt_clr_i = 1'b0; mem_we_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("sw3 wait stall", 32'(stall1), 32'(6'b011111));
            chk("sw3 wait we", 32'(we1), 32'd0);
            advance();
        end
        settle();
        chk("sw3 commit stall", 32'(stall1), 32'(6'b001111));
        chk("sw3 commit we", 32'(we1), 32'd1);
        advance();
        mem_we_i = 1'b0;
        settle();
        chk("sw3 stall count", cnt1, 32'd4);
        chk("sw3 hold we", 32'(we1), 32'd0);
        advance();

        // Vectored exception targets.
        ebase_i = 32'h8000_0000;
        excepttype_i = 32'h01; settle();
        chk("vec int pc", pc1, 32'h8000_0200);
        chk("vec int flush", 32'(flush1), 32'd1);
        chk("vec int stall", 32'(stall1), 32'd0);
        chk("nonvec int pc", pc0, 32'h8000_0000);
        advance();
        excepttype_i = 32'h0C; settle();
        chk("vec gen pc", pc1, 32'h8000_0180);
        advance();
        excepttype_i = 32'h0F; settle();
        chk("vec tlb pc", pc1, 32'h8000_0000);
        advance();
        drive_idle(); settle(); advance();

        // Asynchronous reset in the middle of a STORE_WAIT=3 wait.
        mem_we_i = 1'b1;
        settle(); advance();
        settle();
        #1;
        rst = 1'b0; excepttype_i = 32'h0E; model_reset_all();
        settle();
        chk("rst stall", 32'(stall1), 32'd0);
        chk("rst we", 32'(we1), 32'd0);
        chk("rst flush", 32'(flush1), 32'd0);
        chk("rst new_pc", pc1, 32'd0);
        chk("rst cnt", cnt1, 32'd0);
        excepttype_i = 32'h0;
        advance();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("post-rst stall", 32'(stall1), 32'(6'b011111));
            chk("post-rst no strobe", 32'(we1), 32'd0);
            advance();
        end
        settle();
        chk("post-rst strobe", 32'(we1), 32'd1);
        advance();
        mem_we_i = 1'b0; settle(); advance();

        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            if (!rst) model_reset_all();
            stallreq_i = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
            mem_we_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0:       excepttype_i = 32'h01;
                    1:       excepttype_i = 32'h0C;
                    2:       excepttype_i = 32'h0E;
                    3:       excepttype_i = 32'h0F;
                    default: excepttype_i = 32'($urandom_range(2, 255));
                endcase
            end else begin
                excepttype_i = 32'h0;
            end
            ebase_i = $urandom; cp0_epc_i = $urandom;
            cnt_clr_i = ($urandom_range(0, 31) == 0);
            settle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
